// File: rtl/ln_range_reduce.sv
// Range reduction for ln: x = m * 2^k with m's exponent forced to REDUCE_EXP, k also as exact float.
// Latency: 1 cycle for specials, 2+z for normals, 3+sc+z for denormals (z = leading zeros of |k|, sc = denormal shift).
// Backpressure: in_ready only in IDLE; result held stable while out_valid=1 and out_ready=0.
module ln_range_reduce #(
    // Biased exponent given to m; keep within 120..130 so |k| fits in 8 bits.
    parameter int REDUCE_EXP = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] m_out,
    output logic [8:0]  k_out,
    output logic [31:0] k_float,
    output logic        flag_zero,
    output logic        flag_inf,
    output logic        flag_nan
);

    typedef enum logic [1:0] {IDLE, NORM, CONV, DONE} state_t;

    localparam logic [7:0] RE  = 8'(REDUCE_EXP);
    localparam logic [8:0] RE9 = {1'b0, RE};

    state_t      state;
    logic [23:0] mant;      // denormal mantissa being normalised
    logic [4:0]  sc;        // normalisation shift count
    logic [7:0]  kmag;      // |k|, shifted left during float conversion
    logic [2:0]  z;         // leading-zero count found so far
    logic        k_neg;     // sign of k

    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic [8:0]  k_norm;
    logic [8:0]  k_den;

    assign in_exp  = in[30:23];
    assign in_frac = in[22:0];
    // k for a normal operand: E - REDUCE_EXP
    assign k_norm  = {1'b0, in_exp} - RE9;
    // k for a denormal once its leading one reaches bit 23: 1 - sc - REDUCE_EXP
    assign k_den   = 9'd1 - {4'd0, sc} - RE9;

    // Magnitude of a 9-bit two's complement k; the legal range keeps it within 8 bits.
    function automatic logic [7:0] abs9(input logic [8:0] v);
        logic [8:0] n;
        n = 9'd0 - v;
        return v[8] ? n[7:0] : v[7:0];
    endfunction

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            m_out     <= 32'd0;
            k_out     <= 9'd0;
            k_float   <= 32'd0;
            flag_zero <= 1'b0;
            flag_inf  <= 1'b0;
            flag_nan  <= 1'b0;
            mant      <= 24'd0;
            sc        <= 5'd0;
            kmag      <= 8'd0;
            z         <= 3'd0;
            k_neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready  <= 1'b0;
                        flag_zero <= 1'b0;
                        flag_inf  <= 1'b0;
                        flag_nan  <= 1'b0;
                        k_float   <= 32'd0;
                        sc        <= 5'd0;
                        z         <= 3'd0;
                        if ((in_exp == 8'hFF && in_frac != 23'd0) ||
                            (in[31] && in[30:0] != 31'd0)) begin
                            // NaN or negative nonzero: ln undefined
                            flag_nan  <= 1'b1;
                            m_out     <= 32'h7FC0_0000;
                            k_out     <= 9'd0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (in[30:0] == 31'd0) begin
                            flag_zero <= 1'b1;
                            m_out     <= 32'd0;
                            k_out     <= 9'd0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (in_exp == 8'hFF) begin
                            flag_inf  <= 1'b1;
                            m_out     <= 32'h7F80_0000;
                            k_out     <= 9'd0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (in_exp == 8'd0) begin
                            // Denormal: find the leading one before forming m
                            mant  <= {1'b0, in_frac};
                            state <= NORM;
                        end else begin
                            m_out <= {1'b0, RE, in_frac};
                            k_out <= k_norm;
                            kmag  <= abs9(k_norm);
                            k_neg <= k_norm[8];
                            state <= CONV;
                        end
                    end
                end
                NORM: begin
                    if (mant[23]) begin
                        m_out <= {1'b0, RE, mant[22:0]};
                        k_out <= k_den;
                        kmag  <= abs9(k_den);
                        k_neg <= k_den[8];
                        state <= CONV;
                    end else begin
                        mant <= mant << 1;
                        sc   <= sc + 5'd1;
                    end
                end
                CONV: begin
                    if (kmag == 8'd0) begin
                        k_float   <= 32'd0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (kmag[7]) begin
                        // Leading one at bit 7 after z shifts: |k| = 1.kmag[6:0] * 2^(7-z)
                        k_float   <= {k_neg, 8'd134 - {5'd0, z}, kmag[6:0], 16'd0};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        kmag <= kmag << 1;
                        z    <= z + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ln_range_reduce.sv
// Bench for ln_range_reduce: directed cases, randomized operands, stall and mid-operation reset.
// Expected values come from an arithmetic reference model of the range reduction.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_ln_range_reduce;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] m_out;
    logic [8:0]  k_out;
    logic [31:0] k_float;
    logic        flag_zero;
    logic        flag_inf;
    logic        flag_nan;

    int checks = 0;
    int errors = 0;

    ln_range_reduce #(.REDUCE_EXP(125)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m_out     (m_out),
        .k_out     (k_out),
        .k_float   (k_float),
        .flag_zero (flag_zero),
        .flag_inf  (flag_inf),
        .flag_nan  (flag_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m;
        logic [8:0]  k;
        logic [31:0] kf;
        logic        fz;
        logic        fi;
        logic        fn;
        int          lat;
    } exp_t;

    // Reference: x = m * 2^k, m in [0.25,0.5) with exponent field 125.
    function automatic exp_t model(input logic [31:0] x);
        exp_t r;
        int e_f, f, k, a, e, sc, zc, p;
        logic [31:0] tmp;
        e_f = int'(x[30:23]);
        f   = int'(x[22:0]);
        r.m = 0; r.k = 0; r.kf = 0; r.fz = 0; r.fi = 0; r.fn = 0; r.lat = 1;
        if ((e_f == 255 && f != 0) || (x[31] && x[30:0] != 0)) begin
            r.fn = 1; r.m = 32'h7FC00000;
            return r;
        end
        if (x[30:0] == 0) begin
            r.fz = 1;
            return r;
        end
        if (e_f == 255) begin
            r.fi = 1; r.m = 32'h7F800000;
            return r;
        end
        if (e_f != 0) begin
            // value = 1.f * 2^(E-127) = (1.f/4) * 2^(E-125)
            k  = e_f - 125;
            sc = -1;
            tmp = {1'b0, 8'd125, x[22:0]};
            r.m = tmp;
        end else begin
            // value = f * 2^-149; leading one at p gives 1.xxx * 2^(p-149)
            p = 0;
            for (int b = 0; b < 23; b++) if ((f >> b) & 1) p = b;
            sc  = 23 - p;
            k   = (p - 149) + 2;
            tmp = 32'((f << (23 - p)) & 32'h007FFFFF);
            r.m = {1'b0, 8'd125, tmp[22:0]};
        end
        r.k = 9'(k);
        a = (k < 0) ? -k : k;
        if (a == 0) begin
            r.kf = 0;
            zc   = 0;
        end else begin
            e = 0;
            for (int b = 0; b < 8; b++) if ((a >> b) & 1) e = b;
            tmp  = 32'((a << (23 - e)) & 32'h007FFFFF);
            r.kf = {(k < 0) ? 1'b1 : 1'b0, 8'(127 + e), tmp[22:0]};
            zc   = 7 - e;
        end
        r.lat = (sc < 0) ? (2 + zc) : (3 + sc + zc);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e);
        check({tag, " m_out"},     m_out,     e.m);
        check({tag, " k_out"},     {23'd0, k_out}, {23'd0, e.k});
        check({tag, " k_float"},   k_float,   e.kf);
        check({tag, " flag_zero"}, {31'd0, flag_zero}, {31'd0, e.fz});
        check({tag, " flag_inf"},  {31'd0, flag_inf},  {31'd0, e.fi});
        check({tag, " flag_nan"},  {31'd0, flag_nan},  {31'd0, e.fn});
    endtask

    // One full transaction; 'hold' cycles of out_ready=0 after the result appears,
    // with a stray in_valid pulse that must be ignored.
    task automatic do_op(input string tag, input logic [31:0] x, input int hold);
        exp_t e;
        int lat;
        e = model(x);
        @(negedge clk);
        check({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in = x;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " latency"}, lat, e.lat);
        check_result(tag, e);
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                in = ~x;
                in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, " hold out_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
            check_result({tag, " hold"}, e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " post out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " post in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        exp_t zero_e;
        logic [31:0] x;
        int cls;

        rst = 1'b1;
        in_valid = 1'b0;
        in = 32'd0;
        out_ready = 1'b0;
        zero_e = '{m: 32'd0, k: 9'd0, kf: 32'd0, fz: 1'b0, fi: 1'b0, fn: 1'b0, lat: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check_result("reset", zero_e);
        rst = 1'b0;

        // Directed cases
        do_op("one",      32'h3F800000, 0);
        do_op("p375",     32'h3EC00000, 0);
        do_op("ten",      32'h41200000, 5);
        do_op("min_den",  32'h00000001, 0);
        do_op("neg_zero", 32'h80000000, 0);
        do_op("neg_one",  32'hBF800000, 0);
        do_op("pos_inf",  32'h7F800000, 0);
        do_op("nan",      32'h7FC00001, 0);
        do_op("pos_zero", 32'h00000000, 0);
        do_op("max_norm", 32'h7F7FFFFF, 0);
        do_op("min_norm", 32'h00800000, 0);
        do_op("max_den",  32'h007FFFFF, 2);

        // Reset in the middle of a denormal normalisation
        @(negedge clk);
        in = 32'h00000001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check_result("midrst", zero_e);
        do_op("after_rst", 32'h3F800000, 0);

        // Randomized operands across all input classes
        for (int i = 0; i < 40; i++) begin
            cls = int'($urandom_range(0, 9));
            if (cls <= 4) begin
                x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            end else if (cls <= 7) begin
                x = {9'd0, 23'($urandom) >> $urandom_range(0, 22)};
                if (x == 32'd0) x = 32'd1;
            end else if (cls == 8) begin
                x = {1'b1, 31'($urandom)};
            end else begin
                x = {1'b0, 8'hFF, 23'($urandom)};
            end
            do_op("rand", x, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
